dcache_dm: RTL and testbench
============================

Name: dcache_dm

Overview:
- Direct-mapped, write-back, write-allocate data cache. It is the responder on the datapath_cache_if data port: it answers dmemREN/dmemWEN/datomic with dhit/dmemload.
- Misses and dirty evictions go to the memory-side data port (dREN/dWEN/daddr/dstore, dload/dwait).
- Supports LL/SC through one link register.
- On datapath halt it writes back all dirty blocks and then raises flushed.

Parameters:
- NSETS, 8, number of sets (power of 2, at least 2)
- IDXW, $clog2(NSETS), index width
- TAGW, 32-IDXW-3, tag width

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- halt  in  1  datapath halted; starts the flush (level-sensitive)
- dmemREN  in  1  datapath read request (LW, LL)
- dmemWEN  in  1  datapath write request (SW, SC)
- datomic  in  1  request is LL (with REN) or SC (with WEN)
- dmemaddr  in  32  word address; bits [1:0] ignored
- dmemstore  in  32  write data
- dhit  out  1  request is complete this cycle
- dmemload  out  32  read data, or SC result (1 = success, 0 = fail)
- flushed  out  1  flush finished; sticky until reset
- dREN  out  1  memory read request
- dWEN  out  1  memory write request
- daddr  out  32  memory word address
- dstore  out  32  memory write data
- dload  in  32  memory read data
- dwait  in  1  memory busy; the word transfer completes in the first cycle dwait=0 while dREN or dWEN is high

Behaviour:
- Address split: tag = [31:IDXW+3], index = [IDXW+2:3], blkoff = [2], [1:0] ignored. Each block holds 2 words.
- Per-set storage: valid, dirty, tag, data[2]. Reset clears valid and dirty in every set; data is don't-care.
- The link register holds {lvalid, laddr[31:2]}; lvalid resets to 0.
- Output reset values: dhit=0, dmemload=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0.
- A hit is combinational in the same cycle: state IDLE, valid set, tag match, and (dmemREN or dmemWEN).
  - Read hit: dmemload = data[blkoff].
  - Write hit: data[blkoff] and dirty are updated at the next clock edge.
- A request with both REN and WEN is illegal; it is asserted against in simulation.
- LL hit: behaves as a read, and at the edge sets lvalid=1, laddr=dmemaddr[31:2].
- SC, evaluated when the SC request is in IDLE:
  - lvalid=1 and laddr matches: the SC is treated as a write (the miss path is allowed). On completion dmemload=1 and lvalid clears.
  - Otherwise: dhit=1 in the same cycle with dmemload=0, no array or memory access, no miss service, and lvalid clears.
- Any completed SW or successful SC to laddr clears lvalid. Halt also clears lvalid.
- Miss FSM states: IDLE, WB0, WB1, LD0, LD1, FLUSH0, FLUSH1, FNEXT, DONE.
  - IDLE, on a miss: goes to WB0 if the victim is valid and dirty, else to LD0.
  - WB0/WB1: dWEN=1, daddr={victim tag, index, 0/1, 2'b00}, dstore=data[0/1]. Advances when dwait=0. WB1 goes to LD0.
  - LD0/LD1: dREN=1, daddr={req tag, index, 0/1, 2'b00}. On dwait=0 the word is written into data[0/1]. LD1 completes by setting valid=1, dirty=0, and the new tag, then returns to IDLE.
  - The replayed request then hits. Miss latency = 2 or 4 memory transfers plus 1 cycle.
  - The datapath holds its request stable until dhit. dhit is never asserted outside IDLE/DONE.
- Flush: halt=1 in IDLE (no miss in progress) starts a set counter fidx at 0.
  - Entry states: FLUSH0 if set fidx is dirty, else FNEXT.
  - FLUSH0/FLUSH1 write both words of set fidx as above, clear dirty, then go to FNEXT.
  - FNEXT increments fidx; at NSETS-1 it goes to DONE; otherwise it goes to FLUSH0 if the next set is dirty, else stays in FNEXT.
  - A halt arriving mid-miss waits for the miss to finish.
  - DONE: flushed=1 and stays there until reset. No dhit is given during the flush.
- Reset mid-transaction: every state returns to IDLE asynchronously and dREN/dWEN drop immediately.
- The fidx counter is IDXW+1 bits wide, so it does not wrap before the termination check.

Decomposition:
- Add dcache_state_t (FSM states) and dcache_frame_t ({valid, dirty, tag, data[2]}) to the shared cpu_types_pkg. The field widths are derived from NSETS via a package localparam.
- One sub-module, dcache_link_reg: holds LL/SC link state. Inputs: set, clear, address compare. Output: sc_ok.

Test Plan:
- Cold read miss: LW 0x0000_0040 with memory[0x40]=0xDEAD_BEEF, [0x44]=0x1234_5678, dwait low after 2 cycles per word → two dREN transfers at 0x40 and 0x44, then dhit with dmemload=0xDEADBEEF. A following LW 0x44 hits in the same cycle with dmemload 0x12345678.
- Dirty eviction: SW 0x40←0xAAAA_0001, then LW 0x80 (same index 0) → WB0/WB1 write 0xAAAA0001 to daddr 0x40 and the old word to 0x44, then LD0/LD1 at 0x80/0x84, then dhit.
- LL/SC success: LL 0x100 then SC 0x100←7 → dmemload=1 on the SC dhit; a later LW 0x100 returns 7; lvalid=0 afterwards.
- SC failure: LL 0x100, SW 0x100←5, SC 0x100←9 → SC gives dhit in 1 cycle with dmemload=0; a later LW 0x100 returns 5; no dWEN pulse is issued.
- Flush: dirty sets 0 and 5, halt=1 → exactly 4 dWEN transfers at the addresses of sets 0 and 5 only, then flushed=1 and it holds.
- Async reset during LD1 with dwait=1 → dREN drops without a clock edge, flushed=0, and the next LW to the same address misses again.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the data cache (miss FSM states, per-set frame)
package cpu_types_pkg;
   localparam int DC_NSETS = 8;
   localparam int DC_IDXW = $clog2(DC_NSETS);
   localparam int DC_TAGW = 32 - DC_IDXW - 3;
   typedef enum logic [3:0] {IDLE, WB0, WB1, LD0, LD1, FLUSH0, FLUSH1, FNEXT, DONE} dcache_state_t;
   typedef struct packed {
      logic valid;
      logic dirty;
      logic [DC_TAGW-1:0] tag;
      logic [1:0][31:0] data;
   } dcache_frame_t;
endpackage

// File: rtl/dcache_link_reg.sv
// dcache_link_reg: LL/SC link register {lvalid, laddr}
//   CLK/nRST  clock, async active-low reset
//   set       LL completed: capture addr and mark the link valid
//   clear     drop the link (wins over set)
//   addr      current word address, captured on set and compared for sc_ok
//   sc_ok     link valid and addr matches the linked word
module dcache_link_reg (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        set,
   input  logic        clear,
   input  logic [29:0] addr,
   output logic        sc_ok
);
   logic lvalid;
   logic [29:0] laddr;
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         lvalid <= 1'b0;
         laddr <= '0;
      end else if (clear) lvalid <= 1'b0;
      else if (set) begin
         lvalid <= 1'b1;
         laddr <= addr;
      end
   end
   assign sc_ok = lvalid && laddr == addr;
endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-back write-allocate data cache with LL/SC and halt flush
//   CLK/nRST                        clock, async active-low reset
//   halt                            write back every dirty block, then raise flushed (sticky)
//   dmemREN/dmemWEN/datomic         datapath request (LW/LL, SW/SC), held until dhit
//   dmemaddr/dmemstore              word address and write data
//   dhit/dmemload                   combinational completion, read data or SC result
//   dREN/dWEN/daddr/dstore          memory-side word request
//   dload/dwait                     memory read data; a word moves on the first dwait=0 cycle
module dcache_dm
   import cpu_types_pkg::*;
#(
   parameter int NSETS = DC_NSETS,
   parameter int IDXW = $clog2(NSETS),
   parameter int TAGW = 32 - IDXW - 3
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        halt,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic        datomic,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic [31:0] dload,
   input  logic        dwait
);
   dcache_state_t state, nxt;
   dcache_frame_t frames [NSETS];
   dcache_frame_t fr, ff;
   logic [TAGW-1:0] tag;
   logic [IDXW-1:0] idx, fi, nf;
   logic [IDXW:0] fidx;
   logic off, b, req, sc, sc_ok, sc_fail, tag_hit, last, wr_hit, unused;
   assign tag = dmemaddr[31:IDXW+3];
   assign idx = dmemaddr[IDXW+2:3];
   assign off = dmemaddr[2];
   assign unused = ^dmemaddr[1:0];
   assign fr = frames[idx];
   assign fi = fidx[IDXW-1:0];
   assign nf = fi + 1'b1;
   assign ff = frames[fi];
   // fidx has a spare top bit so the last-set test never sees a wrapped value
   assign last = fidx == (IDXW+1)'(NSETS - 1);
   assign b = state inside {WB1, LD1, FLUSH1};
   assign req = dmemREN | dmemWEN;
   assign sc = dmemWEN & datomic;
   assign sc_fail = sc & ~sc_ok;
   assign tag_hit = fr.valid && fr.tag == tag;
   assign wr_hit = dhit & dmemWEN & ~sc_fail;
   assign flushed = state == DONE;
   dcache_link_reg u_link (
      .CLK(CLK),
      .nRST(nRST),
      .set(dhit && dmemREN && datomic),
      .clear(halt || (dhit && dmemWEN && (datomic || sc_ok))),
      .addr(dmemaddr[31:2]),
      .sc_ok(sc_ok)
   );
   always_comb begin
      nxt = state;
      dhit = 1'b0;
      dmemload = '0;
      dREN = 1'b0;
      dWEN = 1'b0;
      daddr = '0;
      dstore = '0;
      case (state)
         IDLE: begin
            if (halt) nxt = frames[0].dirty ? FLUSH0 : FNEXT;
            else if (sc_fail) dhit = 1'b1;
            else if (req && tag_hit) begin
               dhit = 1'b1;
               dmemload = dmemREN ? fr.data[off] : {31'd0, sc};
            end else if (req) nxt = (fr.valid && fr.dirty) ? WB0 : LD0;
         end
         WB0, WB1: begin
            dWEN = 1'b1;
            daddr = {fr.tag, idx, b, 2'b00};
            dstore = fr.data[b];
            if (!dwait) nxt = b ? LD0 : WB1;
         end
         LD0, LD1: begin
            dREN = 1'b1;
            daddr = {tag, idx, b, 2'b00};
            if (!dwait) nxt = b ? IDLE : LD1;
         end
         FLUSH0, FLUSH1: begin
            dWEN = 1'b1;
            daddr = {ff.tag, fi, b, 2'b00};
            dstore = ff.data[b];
            if (!dwait) nxt = b ? FNEXT : FLUSH1;
         end
         FNEXT: nxt = last ? DONE : frames[nf].dirty ? FLUSH0 : FNEXT;
         default: nxt = DONE;
      endcase
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         fidx <= '0;
         for (int i = 0; i < NSETS; i++) frames[i] <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && halt) fidx <= '0;
         else if (state == FNEXT && !last) fidx <= fidx + 1'b1;
         if (wr_hit) begin
            frames[idx].data[off] <= dmemstore;
            frames[idx].dirty <= 1'b1;
         end
         if (dREN && !dwait) begin
            frames[idx].data[b] <= dload;
            if (b) begin
               frames[idx].valid <= 1'b1;
               frames[idx].dirty <= 1'b0;
               frames[idx].tag <= tag;
            end
         end
         if (state == FLUSH1 && !dwait) frames[fi].dirty <= 1'b0;
      end
   end
   a_rw_excl: assert property (@(posedge CLK) disable iff (!nRST) !(dmemREN && dmemWEN));
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed vectors for dcache_dm against a 3-cycle-per-word memory model
module tb_dcache_dm;
   logic CLK = 1'b0, nRST = 1'b0;
   logic halt = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0, stall = 1'b0;
   logic dhit, flushed, dREN, dWEN, dwait;
   logic [31:0] dmemaddr = '0, dmemstore = '0, dmemload, daddr, dstore, dload;
   logic [31:0] mem [256];
   logic [31:0] wr_a [$], wr_d [$], rd_a [$];
   bit init_done = 1'b0;
   int wcnt, nvec = 0, nerr = 0;

   dcache_dm dut (
      .CLK(CLK), .nRST(nRST), .halt(halt),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
      .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] memval(input logic [31:0] a);
      return a == 32'h40 ? 32'hDEAD_BEEF : a == 32'h44 ? 32'h1234_5678 : (32'hC0DE_0000 | a);
   endfunction

   // each word: two busy cycles, then dwait=0 for the transfer cycle
   assign dwait = stall || !((dREN || dWEN) && wcnt >= 2);
   assign dload = mem[daddr[9:2]];
   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wcnt <= 0;
         if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= memval(32'(i * 4));
            init_done <= 1'b1;
         end
      end else if ((dREN || dWEN) && !dwait) begin
         wcnt <= 0;
         if (dWEN) begin
            mem[daddr[9:2]] <= dstore;
            wr_a.push_back(daddr);
            wr_d.push_back(dstore);
         end else rd_a.push_back(daddr);
      end else if (dREN || dWEN) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   task automatic acc(input logic r, input logic w, input logic a, input logic [31:0] ad,
                      input logic [31:0] st, output logic [31:0] ld, output int cyc);
      @(negedge CLK);
      dmemREN = r;
      dmemWEN = w;
      datomic = a;
      dmemaddr = ad;
      dmemstore = st;
      #1;
      cyc = 0;
      while (!dhit && cyc < 200) begin
         @(negedge CLK);
         #1;
         cyc++;
      end
      if (!dhit) chk("dhit_timeout", 32'(dhit), 32'd1);
      ld = dmemload;
      @(posedge CLK);
      #1;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      datomic = 1'b0;
   endtask

   initial begin
      logic [31:0] ld;
      int cyc;
      #3;
      chk("rst_dhit", 32'(dhit), 0);
      chk("rst_dren", 32'(dREN), 0);
      chk("rst_dwen", 32'(dWEN), 0);
      chk("rst_flushed", 32'(flushed), 0);
      chk("rst_daddr", daddr, 0);
      chk("rst_dmemload", dmemload, 0);
      repeat (2) @(negedge CLK);
      nRST = 1'b1;

      rd_a.delete();
      acc(1, 0, 0, 32'h40, 0, ld, cyc);
      chk("cold_data", ld, 32'hDEAD_BEEF);
      chk("cold_cyc", cyc, 7);
      chk("cold_nrd", rd_a.size(), 2);
      chk("cold_rd0", rd_a[0], 32'h40);
      chk("cold_rd1", rd_a[1], 32'h44);
      acc(1, 0, 0, 32'h44, 0, ld, cyc);
      chk("hit_data", ld, 32'h1234_5678);
      chk("hit_cyc", cyc, 0);

      acc(0, 1, 0, 32'h40, 32'hAAAA_0001, ld, cyc);
      chk("sw_hit_cyc", cyc, 0);
      rd_a.delete();
      wr_a.delete();
      wr_d.delete();
      acc(1, 0, 0, 32'h80, 0, ld, cyc);
      chk("evict_data", ld, memval(32'h80));
      chk("evict_cyc", cyc, 13);
      chk("evict_nwr", wr_a.size(), 2);
      chk("evict_wa0", wr_a[0], 32'h40);
      chk("evict_wd0", wr_d[0], 32'hAAAA_0001);
      chk("evict_wa1", wr_a[1], 32'h44);
      chk("evict_wd1", wr_d[1], 32'h1234_5678);
      chk("evict_rd0", rd_a[0], 32'h80);
      chk("evict_rd1", rd_a[1], 32'h84);

      acc(1, 0, 1, 32'h100, 0, ld, cyc);
      chk("ll_data", ld, memval(32'h100));
      chk("ll_cyc", cyc, 7);
      acc(0, 1, 1, 32'h100, 32'd7, ld, cyc);
      chk("sc_ok_result", ld, 1);
      acc(1, 0, 0, 32'h100, 0, ld, cyc);
      chk("sc_ok_data", ld, 7);
      acc(0, 1, 1, 32'h100, 32'd8, ld, cyc);
      chk("sc_relink_result", ld, 0);
      acc(1, 0, 0, 32'h100, 0, ld, cyc);
      chk("sc_relink_data", ld, 7);

      wr_a.delete();
      acc(1, 0, 1, 32'h100, 0, ld, cyc);
      acc(0, 1, 0, 32'h100, 32'd5, ld, cyc);
      acc(0, 1, 1, 32'h100, 32'd9, ld, cyc);
      chk("sc_fail_cyc", cyc, 0);
      chk("sc_fail_result", ld, 0);
      acc(1, 0, 0, 32'h100, 0, ld, cyc);
      chk("sc_fail_data", ld, 5);
      chk("sc_fail_nwr", wr_a.size(), 0);

      acc(0, 1, 0, 32'h28, 32'h55, ld, cyc);
      chk("set5_cyc", cyc, 7);

      wr_a.delete();
      wr_d.delete();
      @(negedge CLK);
      halt = 1'b1;
      cyc = 0;
      while (!flushed && cyc < 1000) begin
         @(negedge CLK);
         cyc++;
      end
      chk("flushed", 32'(flushed), 1);
      chk("flush_nwr", wr_a.size(), 4);
      chk("flush_wa0", wr_a[0], 32'h100);
      chk("flush_wd0", wr_d[0], 32'd5);
      chk("flush_wa1", wr_a[1], 32'h104);
      chk("flush_wd1", wr_d[1], memval(32'h104));
      chk("flush_wa2", wr_a[2], 32'h28);
      chk("flush_wd2", wr_d[2], 32'h55);
      chk("flush_wa3", wr_a[3], 32'h2C);
      chk("flush_wd3", wr_d[3], memval(32'h2C));
      repeat (5) @(negedge CLK);
      chk("flushed_hold", 32'(flushed), 1);
      chk("flush_nwr_hold", wr_a.size(), 4);

      halt = 1'b0;
      nRST = 1'b0;
      #1;
      chk("rst2_flushed", 32'(flushed), 0);
      @(negedge CLK);
      nRST = 1'b1;
      rd_a.delete();
      @(negedge CLK);
      dmemREN = 1'b1;
      dmemaddr = 32'h40;
      cyc = 0;
      while (rd_a.size() < 1 && cyc < 100) begin
         @(negedge CLK);
         cyc++;
      end
      stall = 1'b1;
      repeat (2) @(negedge CLK);
      #1;
      chk("ld1_dren", 32'(dREN), 1);
      chk("ld1_daddr", daddr, 32'h44);
      #2;
      nRST = 1'b0;
      #1;
      chk("arst_dren", 32'(dREN), 0);
      chk("arst_dwen", 32'(dWEN), 0);
      chk("arst_flushed", 32'(flushed), 0);
      dmemREN = 1'b0;
      stall = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      acc(1, 0, 0, 32'h40, 0, ld, cyc);
      chk("remiss_cyc", cyc, 7);
      chk("remiss_data", ld, 32'hAAAA_0001);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
